fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction fetch and program-counter sequencer feeding the clocked control unit (`singlecyclectrl`). Holds the PC, latches the instruction word into an instruction register, and presents opcode/funct and decoded fields. Steps a three-state FETCH/DECODE/EXEC sequence so the control unit's registered outputs are valid before the PC is committed. Computes next PC from the control unit's Branch/Jump/selectRegorJump/PCenable outputs and the ALU zero flag, and produces the JAL link value.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pc_enable`  in  1  PCenable from control unit; low freezes the PC.
- `branch`  in  1  Branch from control unit (BNE semantics).
- `jump`  in  1  Jump from control unit.
- `sel_reg_or_jump`  in  1  selectRegorJump from control unit; 1 selects `rs_data` as jump target.
- `alu_zero`  in  1  ALU zero flag from the datapath.
- `rs_data`  in  32  register-file R[rs], used by JR.
- `imem_rdata`  in  32  instruction memory read data, combinational from `imem_addr`.
- `imem_addr`  out  32  instruction memory address; equals `pc`.
- `pc`  out  32  current PC.
- `ir`  out  32  instruction register.
- `op`  out  6  `ir[31:26]`, to control unit Op.
- `funct`  out  6  `ir[5:0]`, to control unit Funct.
- `rs`, `rt`, `rd`  out  5 each  `ir[25:21]`, `ir[20:16]`, `ir[15:11]`.
- `imm16`  out  16  `ir[15:0]`.
- `link_addr`  out  32  PC+8 of the instruction in `ir`, JAL write data.
- `exec_valid`  out  1  high exactly during EXEC; qualifies register/memory writes.
- `halted`  out  1  high once halt opcode decoded.
- `retired_count`  out  32  instructions retired (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, HALT.
- FETCH: `ir <= imem_rdata`; `link_addr <= pc + 8`; next DECODE.
- DECODE: control unit samples `op`/`funct` this edge. If `op == 6'h3f`: next HALT, else EXEC.
- EXEC: control outputs valid; `exec_valid` = 1. At end of cycle, if `pc_enable`, commit next PC (priority order):
  - `jump && sel_reg_or_jump`: `{rs_data[31:2], 2'b00}` (low bits forced to zero).
  - `jump`: `{pc_plus4[31:28], ir[25:0], 2'b00}`.
  - `branch && !alu_zero`: `pc + 4 + (sign-extended imm16 << 2)`.
  - else `pc + 4`.
  - If `pc_enable` = 0, PC holds and the same address is refetched. Next state FETCH.
- All PC arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 silently.
- HALT: absorbing; PC, `ir` frozen; `halted` = 1; `exec_valid` = 0; left only via reset.
- Undefined opcodes go through EXEC normally and advance PC by 4.

## Timing
- Reset (rst_n low at posedge): state FETCH, `pc` = RESET_PC, `ir` = 0, `link_addr` = 0, `exec_valid` = 0, `halted` = 0, `retired_count` = 0. The first fetch occurs in the first cycle after rst_n is sampled high.
- Exactly 3 cycles per retired instruction. PC is updated on the EXEC→FETCH edge.
- `op`/`funct` are stable from the cycle after FETCH through the end of EXEC.
- Reset asserted in any state, including EXEC and HALT, overrides everything that cycle. No partial PC commit occurs.
- `branch` and `jump` both high: jump wins.
- `exec_valid`, `halted`, `imem_addr` are registered-state-derived. No combinational path from inputs.

## Configuration
- `FETCH_PERF_EN` defined: `retired_count` increments by 1 on every EXEC→FETCH transition with `pc_enable` = 1. It wraps at 2^32 and is frozen in HALT.
- Not defined: counter logic is omitted and `retired_count` is tied to 0.

## Test plan
- Reset release with RESET_PC=0, memory holding `add` at 0 → `imem_addr` 0, 4, 8 at cycles 1, 4, 7; `exec_valid` pulses once per 3 cycles.
- BNE at PC 0x10 with imm16=0xFFFE, `alu_zero`=0 → next PC 0x0C. Same instruction with `alu_zero`=1 → next PC 0x14.
- J at PC 0x3000_0004 with target field 0x40 → next PC 0x3000_0100. JAL at PC 0x20 → `link_addr` = 0x28.
- JR with `rs_data`=0x0000_0103 → next PC 0x0000_0100. JR with `branch` also high → jump target taken.
- `pc_enable`=0 during EXEC at PC 0x8 → PC stays 0x8, refetched. Opcode 0x3f → `halted`=1 after DECODE, PC frozen, no further `exec_valid`.
- rst_n low in the EXEC cycle of a jump → PC = RESET_PC, state FETCH. With `FETCH_PERF_EN`, after 5 retired instructions `retired_count`=5. Without the macro, `retired_count` stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch and program-counter sequencer for a multi-cycle MIPS-style
// core. It holds the PC and latches the instruction word into an instruction
// register. It presents the opcode, funct and decoded fields to the clocked
// control unit. A FETCH -> DECODE -> EXEC sequence gives the control unit's
// registered outputs time to settle before the PC is committed on the
// EXEC -> FETCH edge.
//
// Optional feature macro: FETCH_PERF_EN
//   defined     : retired_count counts instructions retired with pc_enable=1.
//   not defined : the counter logic is omitted and retired_count is tied to 0.
//
// Ports
//   clk              in   system clock, all state updates on posedge
//   rst_n            in   synchronous active-low reset
//   pc_enable        in   PCenable from the control unit; low freezes the PC
//   branch           in   Branch from the control unit (BNE semantics)
//   jump             in   Jump from the control unit
//   sel_reg_or_jump  in   1 selects rs_data as the jump target (JR)
//   alu_zero         in   ALU zero flag from the datapath
//   rs_data          in   R[rs] from the register file, used by JR
//   imem_rdata       in   instruction memory read data (combinational)
//   imem_addr        out  instruction memory address, equals pc
//   pc               out  current PC
//   ir               out  instruction register
//   op/funct         out  ir[31:26] / ir[5:0]
//   rs/rt/rd         out  ir[25:21] / ir[20:16] / ir[15:11]
//   imm16            out  ir[15:0]
//   link_addr        out  PC+8 of the instruction in ir (JAL write data)
//   exec_valid       out  high exactly during EXEC
//   halted           out  high once the halt opcode has been decoded
//   retired_count    out  retired-instruction counter (see macro above)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_enable,
  input  logic        branch,
  input  logic        jump,
  input  logic        sel_reg_or_jump,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] link_addr,
  output logic        exec_valid,
  output logic        halted,
  output logic [31:0] retired_count
);

  localparam logic [5:0] OP_HALT = 6'h3f;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_link_addr;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_off;
  logic [31:0] w_next_pc;
  logic        w_commit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so every path drives the signal; without it
    // an incomplete case would infer a latch.
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = (r_ir[31:26] == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_next_state = ST_FETCH;
      ST_HALT:   w_next_state = ST_HALT;
      default:   w_next_state = ST_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-PC selection. Jump outranks branch; a register jump outranks the
  // pseudo-direct jump. All arithmetic wraps modulo 2^32.
  // ---------------------------------------------------------------------------
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_branch_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump && sel_reg_or_jump) begin
      w_next_pc = {rs_data[31:2], 2'b00};
    end else if (jump) begin
      w_next_pc = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
    end else if (branch && !alu_zero) begin
      w_next_pc = w_pc_plus4 + w_branch_off;
    end
  end

  // The PC moves only on the EXEC -> FETCH edge; with pc_enable low the same
  // address is simply fetched again.
  assign w_commit = (r_state == ST_EXEC) && pc_enable;

  // ---------------------------------------------------------------------------
  // State, PC and instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_n) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_link_addr <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH) begin
        r_ir        <= imem_rdata;
        r_link_addr <= r_pc + 32'd8;
      end
      if (w_commit) begin
        r_pc <= w_next_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional retired-instruction counter. HALT never reaches EXEC, so the
  // count is frozen there without extra gating.
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired_count = r_retired;
`else
  assign retired_count = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state only
  // ---------------------------------------------------------------------------
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign op         = r_ir[31:26];
  assign funct      = r_ir[5:0];
  assign rs         = r_ir[25:21];
  assign rt         = r_ir[20:16];
  assign rd         = r_ir[15:11];
  assign imm16      = r_ir[15:0];
  assign link_addr  = r_link_addr;
  assign exec_valid = (r_state == ST_EXEC);
  assign halted     = (r_state == ST_HALT);

endmodule
